// File: rtl/flag_check_seq.sv
// flag_check_seq: valid/ready sequencer that streams a flag through the
// transform core and grades it against a ROM. Option: FLAG_CHECK_EARLY_ABORT_EN.
module flag_check_seq #(
    parameter int FLAG_LEN = 32,
    parameter int CORE_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       core_rst,
    output logic [7:0] core_inp,
    input  logic [7:0] core_res,
    output logic [7:0] exp_addr,
    input  logic [7:0] exp_data,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] mismatch_cnt
);

    localparam int CW = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [7:0] LAST = 8'(FLAG_LEN - 1);
    localparam logic [CW-1:0] WLOAD = CW'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_CMP,
        S_DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [7:0]    idx;
    logic [7:0]    idx_nx;
    logic [CW-1:0] wcnt;
    logic [CW-1:0] wcnt_nx;
    logic          core_rst_nx;
    logic [7:0]    core_inp_nx;
    logic          busy_nx;
    logic          done_nx;
    logic          pass_nx;
    logic [7:0]    mcnt_nx;

    logic          miss;
    logic          last;
    logic [7:0]    mcnt_inc;

    assign in_ready = (state == S_LOAD);
    // idx is stable from LOAD through CMP, so the ROM has settled by CMP
    assign exp_addr = idx;

    assign miss     = (core_res != exp_data);
    assign last     = (idx == LAST);
    assign mcnt_inc = (mismatch_cnt == 8'hFF) ? mismatch_cnt
                                              : mismatch_cnt + 8'd1;

    always_comb begin
        state_nx    = state;
        idx_nx      = idx;
        wcnt_nx     = wcnt;
        core_rst_nx = core_rst;
        core_inp_nx = core_inp;
        busy_nx     = busy;
        done_nx     = 1'b0;
        pass_nx     = pass;
        mcnt_nx     = mismatch_cnt;
        if (abort && state != S_IDLE) begin
            // cancel takes priority over any handshake this cycle
            state_nx    = S_IDLE;
            busy_nx     = 1'b0;
            core_rst_nx = 1'b1;
            pass_nx     = 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state_nx = S_LOAD;
                        busy_nx  = 1'b1;
                        idx_nx   = 8'd0;
                        mcnt_nx  = 8'd0;
                        pass_nx  = 1'b0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        core_inp_nx = in_data;
                        core_rst_nx = 1'b0;
                        wcnt_nx     = WLOAD;
                        state_nx    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wcnt == '0) begin
                        state_nx = S_CMP;
                    end else begin
                        wcnt_nx = wcnt - CW'(1);
                    end
                end
                S_CMP: begin
`ifdef FLAG_CHECK_EARLY_ABORT_EN
                    if (miss) begin
                        mcnt_nx  = 8'd1;
                        state_nx = S_DONE;
                    end else if (last) begin
                        state_nx = S_DONE;
                    end else begin
                        idx_nx   = idx + 8'd1;
                        state_nx = S_LOAD;
                    end
`else
                    if (miss) begin
                        mcnt_nx = mcnt_inc;
                    end
                    if (last) begin
                        state_nx = S_DONE;
                    end else begin
                        idx_nx   = idx + 8'd1;
                        state_nx = S_LOAD;
                    end
`endif
                end
                S_DONE: begin
                    done_nx     = 1'b1;
                    pass_nx     = (mismatch_cnt == 8'd0);
                    core_rst_nx = 1'b1;
                    busy_nx     = 1'b0;
                    state_nx    = S_IDLE;
                end
                default: begin
                    state_nx = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            idx          <= 8'd0;
            wcnt         <= '0;
            core_rst     <= 1'b1;
            core_inp     <= 8'd0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            mismatch_cnt <= 8'd0;
        end else begin
            state        <= state_nx;
            idx          <= idx_nx;
            wcnt         <= wcnt_nx;
            core_rst     <= core_rst_nx;
            core_inp     <= core_inp_nx;
            busy         <= busy_nx;
            done         <= done_nx;
            pass         <= pass_nx;
            mismatch_cnt <= mcnt_nx;
        end
    end

endmodule

// File: tb/tb_flag_check_seq.sv
// tb_flag_check_seq: three sequencer instances with a xor-5A core model and
// ROM model, random flags and valid patterns graded by a run-level model.
module tb_flag_check_seq;

    localparam int ND = 3;

    function automatic int len_of(input int d);
        return (d == 0) ? 4 : (d == 1) ? 1 : 255;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : 1;
    endfunction

    logic       clk = 1'b0;
    logic       rst;
    logic       start    [ND];
    logic       abort    [ND];
    logic       in_valid [ND];
    logic [7:0] in_data  [ND];
    logic       in_ready [ND];
    logic       core_rst [ND];
    logic [7:0] core_inp [ND];
    logic [7:0] core_res [ND];
    logic [7:0] exp_addr [ND];
    logic [7:0] exp_data [ND];
    logic       busy     [ND];
    logic       done     [ND];
    logic       pass     [ND];
    logic [7:0] mcnt     [ND];

    logic [7:0] gold [ND][256];
    logic [7:0] flag [256];
    bit         vpat [4096];
    int         p_src;
    int         nerr = 0;
    int         nchk = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        localparam int LEN = len_of(g);
        localparam int LAT = lat_of(g);
        logic [7:0] p1;
        logic [7:0] p2;
        logic [7:0] rom_q;

        flag_check_seq #(.FLAG_LEN(LEN), .CORE_LAT(LAT)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .start       (start[g]),
            .abort       (abort[g]),
            .in_valid    (in_valid[g]),
            .in_data     (in_data[g]),
            .in_ready    (in_ready[g]),
            .core_rst    (core_rst[g]),
            .core_inp    (core_inp[g]),
            .core_res    (core_res[g]),
            .exp_addr    (exp_addr[g]),
            .exp_data    (exp_data[g]),
            .busy        (busy[g]),
            .done        (done[g]),
            .pass        (pass[g]),
            .mismatch_cnt(mcnt[g])
        );

        always @(posedge clk) begin
            p1    <= core_rst[g] ? core_inp[g] : (core_inp[g] ^ 8'h5A);
            p2    <= p1;
            rom_q <= gold[g][exp_addr[g]] ^ 8'h5A;
        end
        assign core_res[g] = (LAT == 1) ? p1 : p2;
        assign exp_data[g] = rom_q;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int d, input bit v);
        bit acc;
        @(negedge clk);
        in_valid[d] = v;
        in_data[d]  = v ? flag[p_src] : 8'($urandom);
        acc = v && (in_ready[d] === 1'b1);
        @(posedge clk);
        if (acc) p_src++;
        #1;
    endtask

    // mode 0: valid always; 1: valid on even cycles only; 2: random
    task automatic run(input int d, input int mode, input bit hold,
                       input string nm);
        int n;
        int lat;
        int t;
        int cnt;
        int nacc;
        int exp_done;
        int got;
        n   = len_of(d);
        lat = lat_of(d);
        for (int c = 0; c < 4096; c++) begin
            if (mode == 0)      vpat[c] = 1'b1;
            else if (mode == 1) vpat[c] = ((c % 2) == 0);
            else                vpat[c] = ($urandom_range(0, 3) != 0);
        end
        t    = 1;
        cnt  = 0;
        nacc = 0;
        for (int i = 0; i < n; i++) begin
            while (!vpat[t] && t < 4000) t++;
            t += lat + 2;
            nacc++;
            if (flag[i] != gold[d][i]) begin
                cnt++;
`ifdef FLAG_CHECK_EARLY_ABORT_EN
                break;
`endif
            end
        end
        exp_done = t;
        if (cnt > 255) cnt = 255;

        @(negedge clk);
        start[d]    = 1'b1;
        in_valid[d] = 1'b1;
        in_data[d]  = 8'($urandom);
        @(posedge clk);
        #1;
        chk({nm, "/busy"}, busy[d], 1);
        if (!hold) start[d] = 1'b0;
        in_valid[d] = 1'b0;
        p_src = 0;
        got   = -1;
        for (int c = 1; c <= exp_done + 20 && got < 0; c++) begin
            step(d, vpat[c]);
            if (done[d] === 1'b1) got = c;
        end
        start[d]    = 1'b0;
        in_valid[d] = 1'b0;
        chk({nm, "/done_cycle"}, got, exp_done);
        chk({nm, "/pass"}, pass[d], (cnt == 0) ? 1 : 0);
        chk({nm, "/mcnt"}, mcnt[d], cnt);
        chk({nm, "/accepted"}, p_src, nacc);
        @(posedge clk);
        #1;
        chk({nm, "/pulse"}, done[d], 0);
        chk({nm, "/busy_end"}, busy[d], 0);
        chk({nm, "/core_rst_end"}, core_rst[d], 1);
    endtask

    task automatic set_flag_ok(input int d);
        for (int i = 0; i < 256; i++) flag[i] = gold[d][i];
    endtask

    initial begin
        int saw;
        rst = 1'b1;
        for (int d = 0; d < ND; d++) begin
            start[d]    = 1'b0;
            abort[d]    = 1'b0;
            in_valid[d] = 1'b0;
            in_data[d]  = 8'd0;
            for (int i = 0; i < 256; i++) gold[d][i] = 8'($urandom);
        end
        gold[0][0] = 8'h42;
        gold[0][1] = 8'h41;
        gold[0][2] = 8'h4D;
        gold[0][3] = 8'h42;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst/in_ready", in_ready[0], 0);
        chk("rst/core_rst", core_rst[0], 1);
        chk("rst/core_inp", core_inp[0], 0);
        chk("rst/exp_addr", exp_addr[0], 0);
        chk("rst/busy", busy[0], 0);
        chk("rst/done", done[0], 0);
        chk("rst/pass", pass[0], 0);
        chk("rst/mcnt", mcnt[0], 0);

        set_flag_ok(0);
        run(0, 0, 1'b0, "bamb");
        flag[2] = 8'h00;
        run(0, 0, 1'b0, "byte2");
        set_flag_ok(0);
        run(0, 1, 1'b0, "toggle");
        run(0, 0, 1'b1, "hold_start");
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 4; i++) begin
                flag[i] = gold[0][i];
                if ($urandom_range(0, 2) == 0)
                    flag[i] = gold[0][i] ^ 8'($urandom_range(1, 255));
            end
            run(0, 2, bit'(r % 2), "rand4");
        end

        // abort in WAIT of byte 1 after a wrong byte 0
        set_flag_ok(0);
        flag[0] = 8'hFF;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        p_src = 0;
        repeat (5) step(0, 1'b1);
        chk("abort/accepted", p_src, 2);
        @(negedge clk);
        abort[0]    = 1'b1;
        in_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        abort[0]    = 1'b0;
        in_valid[0] = 1'b0;
        chk("abort/busy", busy[0], 0);
        chk("abort/core_rst", core_rst[0], 1);
        chk("abort/in_ready", in_ready[0], 0);
        chk("abort/pass", pass[0], 0);
        chk("abort/mcnt_hold", mcnt[0], 1);
        saw = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (done[0] === 1'b1) saw = 1;
        end
        chk("abort/no_done", saw, 0);
        set_flag_ok(0);
        run(0, 0, 1'b0, "after_abort");

        // synchronous reset in CMP of byte 3
        flag[0] = 8'h00;
        flag[1] = 8'h01;
        @(negedge clk);
        start[0] = 1'b1;
        @(posedge clk);
        #1 start[0] = 1'b0;
        p_src = 0;
        repeat (15) step(0, 1'b1);
        chk("midrst/accepted", p_src, 4);
        chk("midrst/mcnt_before", mcnt[0], 2);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        in_valid[0] = 1'b0;
        chk("midrst/in_ready", in_ready[0], 0);
        chk("midrst/core_rst", core_rst[0], 1);
        chk("midrst/core_inp", core_inp[0], 0);
        chk("midrst/exp_addr", exp_addr[0], 0);
        chk("midrst/busy", busy[0], 0);
        chk("midrst/done", done[0], 0);
        chk("midrst/mcnt", mcnt[0], 0);
        saw = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done[0] === 1'b1) saw = 1;
        end
        chk("midrst/no_done", saw, 0);

        set_flag_ok(1);
        run(1, 0, 1'b0, "len1_ok");
        flag[0] = ~gold[1][0];
        run(1, 0, 1'b0, "len1_bad");
        run(1, 2, 1'b0, "len1_rand");

        for (int i = 0; i < 255; i++)
            flag[i] = gold[2][i] ^ 8'($urandom_range(1, 255));
        run(2, 0, 1'b0, "len255_sat");
        set_flag_ok(2);
        for (int i = 0; i < 255; i++)
            if ($urandom_range(0, 15) == 0) flag[i] = ~gold[2][i];
        run(2, 2, 1'b0, "len255_rand");

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
